bcd_updown_counter: RTL and testbench

//  Parametrised N-digit BCD up/down counter; next generation of the 2-digit floor counter.

---
 rtl/bcd_pkg.sv | 33 +++
 rtl/bcd_updown_counter_digit.sv | 34 +++
 rtl/bcd_updown_counter.sv | 85 ++++++++
 tb/tb_bcd_updown_counter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit type, limits and elaboration-time helpers
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_DIGIT_MAX  = 4'd9;
  localparam int         BCD_MAX_DIGITS = 16;

  // Helpers work on a fixed 64-bit container; callers cast to their own width.
  function automatic logic [63:0] to_bcd(int value, int digits);
    logic [63:0] r;
    int          v;
    r = '0;
    v = value;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (i < digits) begin
        r[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

  function automatic logic bcd_valid(logic [63:0] v, int digits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (i < digits && v[4*i +: 4] > BCD_DIGIT_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_digit.sv
// rtl/bcd_updown_counter_digit.sv - one combinational BCD up/down digit stage
module bcd_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t d,
  input  logic       du,
  input  logic       cin,
  output bcd_digit_t d_next,
  output logic       cout
);

  always_comb begin
    d_next = d;
    cout   = 1'b0;
    if (cin) begin
      if (!du) begin
        if (d >= BCD_DIGIT_MAX) begin
          d_next = '0;
          cout   = 1'b1;
        end else begin
          d_next = d + 4'd1;
        end
      end else begin
        if (d == '0) begin
          d_next = BCD_DIGIT_MAX;
          cout   = 1'b1;
        end else begin
          d_next = d - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - N-digit BCD up/down counter with MIN/MAX window and load check
// Optional macro BCD_COUNTER_SATURATE_EN: hold at the limits instead of wrapping.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 99
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_n,
  input  logic                du,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] q,
  output logic                at_min,
  output logic                at_max,
  output logic                wrap_p,
  output logic                load_err
);

  localparam int             W       = 4 * DIGITS;
  localparam logic [W-1:0]   MIN_BCD = W'(to_bcd(MIN_VAL, DIGITS));
  localparam logic [W-1:0]   MAX_BCD = W'(to_bcd(MAX_VAL, DIGITS));

  generate
    if (!(MIN_VAL >= 0 && MIN_VAL < MAX_VAL && MAX_VAL <= 10**DIGITS - 1)) begin : g_bad_params
      $error("bcd_updown_counter: need 0 <= MIN_VAL < MAX_VAL <= 10**DIGITS-1");
    end
  endgenerate

  logic [DIGITS:0] carry;
  logic [W-1:0]    q_step;
  logic            load_ok;
  logic            limit_hit;

  assign carry[0] = ~en_n;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
        .d      (q[4*i +: 4]),
        .du     (du),
        .cin    (carry[i]),
        .d_next (q_step[4*i +: 4]),
        .cout   (carry[i+1])
      );
    end
  endgenerate

  // Valid BCD vectors order the same as their decimal values, so plain compares suffice.
  assign at_min    = (q == MIN_BCD);
  assign at_max    = (q == MAX_BCD);
  assign load_ok   = bcd_valid(64'(load_val), DIGITS) && (load_val >= MIN_BCD) && (load_val <= MAX_BCD);
  // A top-digit carry/borrow implies q sits at all-9s or zero, i.e. already at a limit.
  assign limit_hit = (du ? at_min : at_max) || carry[DIGITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= MIN_BCD;
      wrap_p   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap_p   <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (load_ok) q <= load_val;
        else         load_err <= 1'b1;
      end else if (!en_n) begin
        if (limit_hit) begin
          wrap_p <= 1'b1;
`ifdef BCD_COUNTER_SATURATE_EN
          q <= q;
`else
          q <= du ? MAX_BCD : MIN_BCD;
`endif
        end else begin
          q <= q_step;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - scoreboard bench: full-range and windowed counters vs decimal model
module tb_bcd_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n, en_n, du, load;
  logic [7:0] load_val;
  logic [7:0] q_a, q_b;
  logic       at_min_a, at_max_a, wrap_a, err_a;
  logic       at_min_b, at_max_b, wrap_b, err_b;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(2), .MIN_VAL(0), .MAX_VAL(99)) dut_a (
    .clk(clk), .rst_n(rst_n), .en_n(en_n), .du(du), .load(load), .load_val(load_val),
    .q(q_a), .at_min(at_min_a), .at_max(at_max_a), .wrap_p(wrap_a), .load_err(err_a)
  );

  bcd_updown_counter #(.DIGITS(2), .MIN_VAL(1), .MAX_VAL(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .en_n(en_n), .du(du), .load(load), .load_val(load_val),
    .q(q_b), .at_min(at_min_b), .at_max(at_max_b), .wrap_p(wrap_b), .load_err(err_b)
  );

  typedef struct {
    int tag;
    int qa; bit wa; bit ea;
    int qb; bit wb; bit eb;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   m_a   = 0;
  int   m_b   = 1;

  function automatic int to_bcd2(int v);
    return ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  // Decimal-domain reference: next count from the window rules.
  function automatic int model(int m, int mn, int mx, bit ld, bit lv_ok, int lv,
                               bit en_n_i, bit du_i, output bit wrap, output bit err);
    wrap = 1'b0;
    err  = 1'b0;
    if (ld) begin
      if (lv_ok && lv >= mn && lv <= mx) return lv;
      err = 1'b1;
      return m;
    end
    if (en_n_i) return m;
    if (!du_i) begin
      if (m < mx) return m + 1;
      wrap = 1'b1;
`ifdef BCD_COUNTER_SATURATE_EN
      return m;
`else
      return mn;
`endif
    end
    if (m > mn) return m - 1;
    wrap = 1'b1;
`ifdef BCD_COUNTER_SATURATE_EN
    return m;
`else
    return mx;
`endif
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic drive(bit l, logic [7:0] lv, bit e, bit d);
    exp_t x;
    bit   lv_ok;
    int   dec;
    @(posedge clk);
    #1;
    load     = l;
    load_val = lv;
    en_n     = e;
    du       = d;
    lv_ok    = (lv[7:4] <= 4'd9) && (lv[3:0] <= 4'd9);
    dec      = int'(lv[7:4]) * 10 + int'(lv[3:0]);
    x.tag    = cyc + 1;
    m_a      = model(m_a, 0, 99, l, lv_ok, dec, e, d, x.wa, x.ea);
    m_b      = model(m_b, 1, 12, l, lv_ok, dec, e, d, x.wb, x.eb);
    x.qa     = m_a;
    x.qb     = m_b;
    sb.push_back(x);
  endtask

  task automatic do_async_reset();
    @(posedge clk);
    #3;
    en_n  = 1'b1;
    load  = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rst_q_a", 32'(q_a), 32'h00);
    chk("rst_q_b", 32'(q_b), 32'h01);
    chk("rst_at_min_a", 32'(at_min_a), 32'd1);
    chk("rst_at_min_b", 32'(at_min_b), 32'd1);
    chk("rst_wrap_a", 32'(wrap_a), 32'd0);
    chk("rst_err_b", 32'(err_b), 32'd0);
    #3;
    rst_n = 1'b1;
    m_a   = 0;
    m_b   = 1;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      while (sb.size() > 0 && sb[0].tag <= cyc) begin
        x = sb.pop_front();
        chk("q_a",      32'(q_a),      32'(to_bcd2(x.qa)));
        chk("at_min_a", 32'(at_min_a), 32'(x.qa == 0));
        chk("at_max_a", 32'(at_max_a), 32'(x.qa == 99));
        chk("wrap_a",   32'(wrap_a),   32'(x.wa));
        chk("err_a",    32'(err_a),    32'(x.ea));
        chk("q_b",      32'(q_b),      32'(to_bcd2(x.qb)));
        chk("at_min_b", 32'(at_min_b), 32'(x.qb == 1));
        chk("at_max_b", 32'(at_max_b), 32'(x.qb == 12));
        chk("wrap_b",   32'(wrap_b),   32'(x.wb));
        chk("err_b",    32'(err_b),    32'(x.eb));
      end
    end
  end

  initial begin : stimulus
    logic [3:0] hi, lo;
    rst_n    = 1'b0;
    en_n     = 1'b1;
    du       = 1'b0;
    load     = 1'b0;
    load_val = '0;
    #12;
    rst_n = 1'b1;

    drive(1'b1, 8'h47, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    do_async_reset();

    repeat (99) drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    drive(1'b1, 8'h30, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);

    drive(1'b1, 8'h12, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h13, 1'b1, 1'b0);
    drive(1'b1, 8'h1A, 1'b1, 1'b0);

    drive(1'b1, 8'h55, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    repeat (400) begin
      hi = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
      lo = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      drive($urandom_range(0, 7) == 0, {hi, lo}, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
    end

    drive(1'b0, 8'h00, 1'b1, 1'b0);
    @(posedge clk);
    #4;
    chk("drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
